// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline stage register with optional 2-entry skid.
// Carries pc/ctrl/data/exc. Flush inserts a bubble, exceptions zero ctrl/data
// but keep the pc for EPC capture, and a saturating counter tracks bubble cycles.
module pipe_stage_reg #(
  parameter int              DATA_W    = 128,
  parameter int              CTRL_W    = 24,
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = 'h8000_0000,
  parameter logic [PC_W-1:0] BUBBLE_PC = '0,
  parameter int              SKID      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_exc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_exc,
  output logic [15:0]       bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [1:0]        exc;
  } ent_t;

  ent_t m_q, s_q, beat;
  logic acc, dep, kill;
  logic [15:0] bc_q;

  assign acc  = in_valid & in_ready;
  assign dep  = m_q.valid & out_ready;
  assign kill = |in_exc;

  // Incoming beat; a faulting instruction loses its side effects but keeps pc/exc.
  always_comb begin
    beat       = '0;
    beat.valid = 1'b1;
    beat.pc    = in_pc;
    beat.ctrl  = kill ? '0 : in_ctrl;
    beat.data  = kill ? '0 : in_data;
    beat.exc   = in_exc;
  end

  // Main entry: reset > flush > flow control. Departure clears only valid so a
  // stalled or drained entry keeps its fields bit-exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q    <= '0;
      m_q.pc <= RESET_PC;
    end else if (flush) begin
      m_q    <= '0;
      m_q.pc <= BUBBLE_PC;
    end else if (SKID != 0) begin
      if (!m_q.valid) begin
        if (acc) m_q <= beat;
      end else if (dep) begin
        if (s_q.valid)  m_q <= s_q;
        else if (acc)   m_q <= beat;
        else            m_q.valid <= 1'b0;
      end
    end else begin
      if (acc)        m_q <= beat;
      else if (dep)   m_q.valid <= 1'b0;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Skid entry catches the beat accepted while M is stalled; it is always
      // younger than M and moves into M on the next departure.
      always_ff @(posedge clk) begin
        if (reset || flush)                      s_q <= '0;
        else if (m_q.valid && dep && s_q.valid)  s_q <= '0;
        else if (m_q.valid && !dep && acc)       s_q <= beat;
      end
      assign in_ready = !s_q.valid;
    end else begin : g_noskid
      assign s_q      = '0;
      assign in_ready = !m_q.valid | out_ready;
    end
  endgenerate

  // Saturating count of cycles where downstream was ready but we had nothing.
  always_ff @(posedge clk) begin
    if (reset)                                    bc_q <= '0;
    else if (out_ready && !m_q.valid && bc_q != 16'hFFFF) bc_q <= bc_q + 16'd1;
  end

  assign out_valid  = m_q.valid;
  assign out_pc     = m_q.pc;
  assign out_ctrl   = m_q.ctrl;
  assign out_data   = m_q.data;
  assign out_exc    = m_q.exc;
  assign bubble_cnt = bc_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (SKID=1): cycle table plus bubble counter run.
module tb_pipe_stage_reg;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]  in_pc, out_pc;
  logic [23:0]  in_ctrl, out_ctrl;
  logic [127:0] in_data, out_data;
  logic [1:0]   in_exc, out_exc;
  logic [15:0]  bubble_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_bc;
  logic        prev_ev;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data), .in_exc(in_exc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .out_data(out_data), .out_exc(out_exc),
    .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic rst, iv, fl, ordy;
    logic [31:0] ipc;  logic [23:0] ictrl; logic [127:0] idata; logic [1:0] iexc;
    logic ev, erdy;
    logic [31:0] epc;  logic [23:0] ectrl; logic [127:0] edata; logic [1:0] eexc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [23:0] ctrl_of(input logic [31:0] pc);
    return {8'h00, pc[15:0]};
  endfunction
  function automatic logic [127:0] data_of(input logic [31:0] pc);
    return {pc, ~pc, 32'hC0DE_0000 | pc, pc ^ 32'h5A5A_5A5A};
  endfunction

  // Normal beat row; expected ctrl/data follow the pc encoding, zero for reset/bubble pc.
  function automatic vec_t mk(input logic rst, iv, fl, ordy, input logic [31:0] ipc,
                              input logic ev, erdy, input logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.fl = fl; v.ordy = ordy;
    v.ipc = ipc; v.ictrl = ctrl_of(ipc); v.idata = data_of(ipc); v.iexc = 2'b00;
    v.ev = ev; v.erdy = erdy; v.epc = epc; v.eexc = 2'b00;
    if (epc == RST_PC || epc == 32'h0) begin
      v.ectrl = '0; v.edata = '0;
    end else begin
      v.ectrl = ctrl_of(epc); v.edata = data_of(epc);
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst; in_valid = v.iv; flush = v.fl; out_ready = v.ordy;
    in_pc = v.ipc; in_ctrl = v.ictrl; in_data = v.idata; in_exc = v.iexc;
    if (v.rst)                                   exp_bc = '0;
    else if (v.ordy && !prev_ev && exp_bc != 16'hFFFF) exp_bc = exp_bc + 16'd1;
    @(posedge clk); #1;
    chk($sformatf("row%0d out_valid", idx), 128'(out_valid), 128'(v.ev));
    chk($sformatf("row%0d in_ready", idx),  128'(in_ready),  128'(v.erdy));
    chk($sformatf("row%0d out_pc", idx),    128'(out_pc),    128'(v.epc));
    chk($sformatf("row%0d out_ctrl", idx),  128'(out_ctrl),  128'(v.ectrl));
    chk($sformatf("row%0d out_data", idx),  out_data,        v.edata);
    chk($sformatf("row%0d out_exc", idx),   128'(out_exc),   128'(v.eexc));
    chk($sformatf("row%0d bubble_cnt", idx), 128'(bubble_cnt), 128'(exp_bc));
    prev_ev = v.ev;
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_ctrl = '0; in_data = '0; in_exc = '0;

    // streaming: one beat per cycle, visible one cycle after acceptance
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 0, 1, 32'h100 + 32'(4*i), 1, 1, 32'h100 + 32'(4*i)));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0, 0, 1, 32'h11C));
    // stall and skid: A to M, B to S, 3-cycle stall, then A, B drain in order
    tbl.push_back(mk(0, 1, 0, 0, 32'h200, 1, 1, 32'h200));
    tbl.push_back(mk(0, 1, 0, 0, 32'h204, 1, 0, 32'h200));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 0, 32'h208, 1, 0, 32'h200));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0, 1, 1, 32'h204));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0, 0, 1, 32'h204));
    // flush with M and S full, then flush together with an accepted beat
    tbl.push_back(mk(0, 1, 0, 0, 32'h220, 1, 1, 32'h220));
    tbl.push_back(mk(0, 1, 0, 0, 32'h224, 1, 0, 32'h220));
    tbl.push_back(mk(0, 1, 1, 0, 32'h300, 0, 1, 32'h0));
    tbl.push_back(mk(0, 1, 1, 1, 32'h304, 0, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0, 0, 1, 32'h0));
    // exceptions: ctrl/data zeroed, pc and cause kept
    v = mk(0, 1, 0, 1, 32'h400, 1, 1, 32'h400);
    v.ictrl = '1; v.idata = 128'hDEAD; v.iexc = 2'b10; v.ectrl = '0; v.edata = '0; v.eexc = 2'b10;
    tbl.push_back(v);
    v = mk(0, 1, 0, 1, 32'h404, 1, 1, 32'h404);
    v.ictrl = '1; v.iexc = 2'b01; v.ectrl = '0; v.edata = '0; v.eexc = 2'b01;
    tbl.push_back(v);
    v = mk(0, 0, 0, 1, 32'h0, 0, 1, 32'h404);
    v.ectrl = '0; v.edata = '0; v.eexc = 2'b01;
    tbl.push_back(v);
    // reset while M and S are full: nothing survives
    tbl.push_back(mk(0, 1, 0, 0, 32'h240, 1, 1, 32'h240));
    tbl.push_back(mk(0, 1, 0, 0, 32'h244, 1, 0, 32'h240));
    tbl.push_back(mk(1, 1, 0, 0, 32'h248, 0, 1, RST_PC));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0, 0, 1, RST_PC));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset out_pc",    128'(out_pc),    128'(RST_PC));
    chk("reset out_ctrl",  128'(out_ctrl),  128'(24'h0));
    chk("reset in_ready",  128'(in_ready),  128'(1'b1));
    chk("reset bubble_cnt", 128'(bubble_cnt), 128'(16'h0));
    exp_bc = '0; prev_ev = 1'b0;

    foreach (tbl[i]) step(tbl[i], i);

    // bubble counter saturation
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bc reset", 128'(bubble_cnt), 128'(16'h0));
    @(negedge clk);
    reset = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("bc 65534", 128'(bubble_cnt), 128'(16'hFFFE));
    @(posedge clk); #1;
    chk("bc 65535", 128'(bubble_cnt), 128'(16'hFFFF));
    repeat (70000 - 65535) @(posedge clk);
    #1;
    chk("bc saturated", 128'(bubble_cnt), 128'(16'hFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
